// File: rtl/interrupt_sequencer_pkg.sv
// Shared constants for the 6502 interrupt/reset entry sequencer:
// FSM state encodings, vector addresses and the PSR position of the I flag.
package interrupt_sequencer_pkg;

    localparam logic [2:0] S_RESET    = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_PUSH_PCH = 3'd2;
    localparam logic [2:0] S_PUSH_PCL = 3'd3;
    localparam logic [2:0] S_PUSH_P   = 3'd4;
    localparam logic [2:0] S_VEC_LO   = 3'd5;
    localparam logic [2:0] S_VEC_HI   = 3'd6;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    // psr_in is {N,V,B,D,I,Z,C}
    localparam int PSR_I_BIT = 2;

    typedef enum logic [1:0] {
        VSEL_RST = 2'd0,
        VSEL_NMI = 2'd1,
        VSEL_IRQ = 2'd2
    } vec_sel_t;

    // Low byte address of the selected vector; the high byte sits one above.
    function automatic logic [15:0] vec_base(input vec_sel_t sel);
        case (sel)
            VSEL_NMI: vec_base = VEC_NMI;
            VSEL_IRQ: vec_base = VEC_IRQ;
            default:  vec_base = VEC_RST;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_latch.sv
// NMI rising-edge detector with a sticky pending flag.
// Edge detection runs every cycle regardless of rdy; clear wins over a
// simultaneous edge because the caller folds that edge into its decision.
module nmi_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic nmi,
    input  logic clr,
    output logic nmi_edge,
    output logic nmi_pending
);

    logic nmi_q;

    assign nmi_edge = nmi & ~nmi_q;

    // Track the previous NMI level and latch a pending request on each rise
    always_ff @(posedge clk) begin
        nmi_q <= nmi;
        if (rst) begin
            nmi_pending <= 1'b0;
        end else if (clr) begin
            nmi_pending <= 1'b0;
        end else if (nmi_edge) begin
            nmi_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 reset/NMI/IRQ entry sequencer. Takes the bus from the decoder at an
// instruction boundary, pushes PCH, PCL and P, fetches the vector, loads the
// PC and sets I. Out of reset it runs the RESET vector fetch without pushes.
module interrupt_sequencer #(
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        res,
    input  logic        rdy,
    input  logic        irq,
    input  logic        nmi,
    input  logic        fetch_req,
    input  logic [6:0]  psr_in,
    input  logic [15:0] pc_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  data_in,
    output logic        hold,
    output logic [15:0] address,
    output logic        bus_own,
    output logic        rw,
    output logic [7:0]  data_out,
    output logic        sp_dec,
    output logic        pc_load,
    output logic [15:0] pc_value,
    output logic        set_i
);

    import interrupt_sequencer_pkg::*;

    logic [2:0] state, state_nxt;
    vec_sel_t   vec_sel, vec_sel_nxt;
    logic [7:0] vec_lo;
    logic       nmi_edge, nmi_pending, nmi_now, nmi_clr;
    logic       irq_pending, take;

    // Stacked P: bit 5 always reads 1, B is pushed as 0 for hardware entries
    function automatic logic [7:0] push_psr(input logic [6:0] psr);
        push_psr = {psr[6:5], 1'b1, 1'b0, psr[3:0]};
    endfunction

    nmi_edge_latch u_nmi (
        .clk         (clk),
        .rst         (res),
        .nmi         (nmi),
        .clr         (nmi_clr),
        .nmi_edge    (nmi_edge),
        .nmi_pending (nmi_pending)
    );

    assign irq_pending = irq & ~psr_in[PSR_I_BIT];
    // An edge landing in the last push cycle still counts for this sequence
    assign nmi_now     = nmi_pending | nmi_edge;
    assign take        = (state == S_IDLE) & fetch_req & (nmi_pending | irq_pending);
    assign nmi_clr     = rdy & (state == S_PUSH_P) & nmi_now;

    // Next-state and vector selection; nothing advances while rdy is low
    always_comb begin
        state_nxt   = state;
        vec_sel_nxt = vec_sel;
        if (rdy) begin
            case (state)
                S_RESET: begin
                    state_nxt   = S_VEC_LO;
                    vec_sel_nxt = VSEL_RST;
                end
                S_IDLE:     if (take) state_nxt = S_PUSH_PCH;
                S_PUSH_PCH: state_nxt = S_PUSH_PCL;
                S_PUSH_PCL: state_nxt = S_PUSH_P;
                S_PUSH_P: begin
                    state_nxt   = S_VEC_LO;
                    vec_sel_nxt = nmi_now ? VSEL_NMI : VSEL_IRQ;
                end
                S_VEC_LO:   state_nxt = S_VEC_HI;
                S_VEC_HI:   state_nxt = S_IDLE;
                default:    state_nxt = S_RESET;
            endcase
        end
    end

    // State, vector choice and vector low byte; reset overrides everything
    always_ff @(posedge clk) begin
        if (res) begin
            state   <= S_RESET;
            vec_sel <= VSEL_RST;
            vec_lo  <= 8'h00;
        end else begin
            state   <= state_nxt;
            vec_sel <= vec_sel_nxt;
            if (rdy && (state == S_VEC_LO)) begin
                vec_lo <= data_in;
            end
        end
    end

    // Bus and pulse outputs decoded from the current state
    always_comb begin
        hold     = 1'b1;
        bus_own  = 1'b0;
        rw       = 1'b1;
        address  = 16'h0000;
        data_out = 8'h00;
        sp_dec   = 1'b0;
        pc_load  = 1'b0;
        pc_value = 16'h0000;
        set_i    = 1'b0;
        case (state)
            S_RESET: bus_own = 1'b1;
            S_IDLE:  hold = take;
            S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
                bus_own = 1'b1;
                rw      = 1'b0;
                address = {STACK_PAGE, sp_in};
                sp_dec  = rdy;
                if (state == S_PUSH_PCH) begin
                    data_out = pc_in[15:8];
                end else if (state == S_PUSH_PCL) begin
                    data_out = pc_in[7:0];
                end else begin
                    data_out = push_psr(psr_in);
                end
            end
            S_VEC_LO: begin
                bus_own = 1'b1;
                address = vec_base(vec_sel);
            end
            S_VEC_HI: begin
                bus_own  = 1'b1;
                address  = vec_base(vec_sel) | 16'h0001;
                pc_load  = rdy;
                set_i    = rdy;
                pc_value = {data_in, vec_lo};
            end
            default: hold = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: a sequence-level reference
// model compared every cycle, plus directed scenarios with literal results.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        res, rdy, irq, nmi, fetch_req;
    logic [6:0]  psr_in;
    logic [15:0] pc_in;
    logic [7:0]  sp_in;
    logic [7:0]  data_in;
    logic        hold, bus_own, rw, sp_dec, pc_load, set_i;
    logic [15:0] address, pc_value;
    logic [7:0]  data_out;

    always #5 clk = ~clk;

    interrupt_sequencer #(.STACK_PAGE(8'h01)) dut (
        .clk(clk), .res(res), .rdy(rdy), .irq(irq), .nmi(nmi),
        .fetch_req(fetch_req), .psr_in(psr_in), .pc_in(pc_in), .sp_in(sp_in),
        .data_in(data_in), .hold(hold), .address(address), .bus_own(bus_own),
        .rw(rw), .data_out(data_out), .sp_dec(sp_dec), .pc_load(pc_load),
        .pc_value(pc_value), .set_i(set_i)
    );

    // Memory: vectors FFFA..FFFF from a table, everything else a pattern
    logic [7:0] vec_mem [0:5];
    always_comb begin
        if (address >= 16'hFFFA) data_in = vec_mem[address[2:0] - 3'd2];
        else                     data_in = address[7:0] ^ 8'h5A;
    end

    int n_chk = 0, n_pass = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: where the sequence stands (-1 idle, 0..2 pushes,
    // 3 vector low read, 4 vector high read) and the pending NMI request.
    bit          m_reset = 1'b1;
    int          m_step  = -1;
    logic [15:0] m_vec   = 16'hFFFC;
    logic [7:0]  m_vlo   = 8'h00;
    logic        m_prev  = 1'b0;
    bit          m_pend  = 1'b0;

    // Environment reactions to DUT pulses, applied after the edge
    logic        e_spdec = 1'b0, e_pcload = 1'b0, e_seti = 1'b0;
    logic [15:0] e_pcv = 16'h0;

    // Logs for the directed scenarios
    int          n_pcl, n_spd, n_own, last_pcl_cyc;
    logic [15:0] last_pcv, last_pcaddr;
    logic [31:0] wr_log[$];

    logic        x_hold, x_own, x_rw, x_sp, x_pl, x_si, x_irqp, x_rise;
    logic [15:0] x_addr, x_pv;
    logic [7:0]  x_do;

    // Compare DUT against the model mid-cycle, then advance the model
    always @(negedge clk) begin
        cyc++;
        x_irqp = irq && !psr_in[2];
        x_hold = 1'b1; x_own = 1'b0; x_rw = 1'b1; x_addr = 16'h0; x_do = 8'h0;
        x_sp = 1'b0; x_pl = 1'b0; x_si = 1'b0; x_pv = 16'h0;
        if (m_reset) begin
            x_own = 1'b1;
        end else if (m_step < 0) begin
            x_hold = fetch_req && (m_pend || x_irqp);
        end else if (m_step < 3) begin
            x_own = 1'b1; x_rw = 1'b0; x_addr = {8'h01, sp_in}; x_sp = rdy;
            if (m_step == 0)      x_do = pc_in[15:8];
            else if (m_step == 1) x_do = pc_in[7:0];
            else                  x_do = {psr_in[6], psr_in[5], 1'b1, 1'b0, psr_in[3:0]};
        end else if (m_step == 3) begin
            x_own = 1'b1; x_addr = m_vec;
        end else begin
            x_own = 1'b1; x_addr = m_vec + 16'd1;
            x_pl = rdy; x_si = rdy; x_pv = {data_in, m_vlo};
        end

        chk("hold", 32'(hold), 32'(x_hold));
        chk("bus_own", 32'(bus_own), 32'(x_own));
        chk("rw", 32'(rw), 32'(x_rw));
        chk("sp_dec", 32'(sp_dec), 32'(x_sp));
        chk("pc_load", 32'(pc_load), 32'(x_pl));
        chk("set_i", 32'(set_i), 32'(x_si));
        if (x_own) chk("address", 32'(address), 32'(x_addr));
        if (x_own && (!x_rw || m_reset)) chk("data_out", 32'(data_out), 32'(x_do));
        if (x_pl || m_reset) chk("pc_value", 32'(pc_value), 32'(x_pv));

        if (rdy && bus_own && !rw) wr_log.push_back({8'h00, address, data_out});
        if (sp_dec) n_spd++;
        if (bus_own) n_own++;
        if (pc_load) begin
            n_pcl++; last_pcv = pc_value; last_pcaddr = address; last_pcl_cyc = cyc;
        end
        e_spdec = sp_dec; e_pcload = pc_load; e_seti = set_i; e_pcv = pc_value;

        x_rise = nmi && !m_prev;
        m_prev = nmi;
        if (res) begin
            m_reset = 1'b1; m_step = -1; m_pend = 1'b0;
        end else if (!rdy) begin
            if (x_rise) m_pend = 1'b1;
        end else if (m_reset) begin
            m_reset = 1'b0; m_step = 3; m_vec = 16'hFFFC;
            if (x_rise) m_pend = 1'b1;
        end else if (m_step == 2) begin
            if (m_pend || x_rise) begin m_vec = 16'hFFFA; m_pend = 1'b0; end
            else m_vec = 16'hFFFE;
            m_step = 3;
        end else begin
            if (m_step < 0) begin
                if (fetch_req && (m_pend || x_irqp)) m_step = 0;
            end else if (m_step == 3) begin
                m_vlo = data_in; m_step = 4;
            end else if (m_step == 4) begin
                m_step = -1;
            end else begin
                m_step = m_step + 1;
            end
            if (x_rise) m_pend = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (e_spdec)  sp_in = sp_in - 8'd1;
        if (e_pcload) pc_in = e_pcv;
        if (e_seti)   psr_in[2] = 1'b1;
    endtask

    task automatic clear_logs();
        n_pcl = 0; n_spd = 0; n_own = 0; last_pcl_cyc = 0;
        last_pcv = 16'h0; last_pcaddr = 16'h0;
        wr_log.delete();
    endtask

    int          t0;
    logic [31:0] exp_w [0:2];

    initial begin
        res = 1'b1; rdy = 1'b1; irq = 1'b0; nmi = 1'b0; fetch_req = 1'b0;
        psr_in = 7'b0000100; pc_in = 16'h0200; sp_in = 8'hFF;
        vec_mem[0] = 8'h00; vec_mem[1] = 8'h90;   // NMI -> 9000
        vec_mem[2] = 8'h34; vec_mem[3] = 8'h12;   // RESET -> 1234
        vec_mem[4] = 8'h78; vec_mem[5] = 8'h56;   // IRQ -> 5678
        clear_logs();

        // Reset for 3 cycles, then the RESET vector fetch
        repeat (3) tick();
        res = 1'b0; t0 = cyc + 1;
        repeat (4) tick();
        chk("rst_pcload_count", 32'(n_pcl), 32'd1);
        chk("rst_vector", 32'(last_pcv), 32'h1234);
        chk("rst_latency", 32'(last_pcl_cyc - t0), 32'd2);
        chk("rst_no_spdec", 32'(n_spd), 32'd0);

        // IRQ entry: P = N,Z,C set -> stacked as A3 (bit 5 always one)
        psr_in = 7'b1000011; pc_in = 16'hC005; sp_in = 8'hFF; irq = 1'b1;
        clear_logs();
        fetch_req = 1'b1; t0 = cyc + 1;
        tick();
        fetch_req = 1'b0;
        repeat (5) tick();
        chk("irq_hold_release", 32'(hold), 32'd0);
        exp_w[0] = 32'h0001FFC0; exp_w[1] = 32'h0001FE05; exp_w[2] = 32'h0001FDA3;
        chk("irq_write_count", 32'(wr_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("irq_write", (i < wr_log.size()) ? wr_log[i] : 32'hFFFFFFFF, exp_w[i]);
        chk("irq_vector", 32'(last_pcv), 32'h5678);
        chk("irq_vec_addr", 32'(last_pcaddr), 32'hFFFF);
        chk("irq_latency", 32'(last_pcl_cyc - t0), 32'd5);
        chk("irq_sets_i", 32'(psr_in[2]), 32'd1);
        irq = 1'b0;

        // Masked IRQ: I is now set
        irq = 1'b1; clear_logs();
        fetch_req = 1'b1;
        #1;
        chk("masked_hold", 32'(hold), 32'd0);
        tick();
        fetch_req = 1'b0;
        repeat (6) tick();
        chk("masked_no_bus", 32'(n_own), 32'd0);
        irq = 1'b0;

        // NMI held high across two boundaries: one sequence only
        clear_logs(); nmi = 1'b1;
        repeat (2) tick();
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        repeat (8) tick();
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        repeat (8) tick();
        nmi = 1'b0;
        chk("nmi_once_count", 32'(n_pcl), 32'd1);
        chk("nmi_vec_addr", 32'(last_pcaddr), 32'hFFFB);
        chk("nmi_vector", 32'(last_pcv), 32'h9000);

        // NMI hijacks an IRQ during the PCL push
        psr_in = 7'b0000000; irq = 1'b1; clear_logs();
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        tick();
        nmi = 1'b1; tick(); nmi = 1'b0;
        repeat (4) tick();
        irq = 1'b0;
        chk("hijack_count", 32'(n_pcl), 32'd1);
        chk("hijack_vec_addr", 32'(last_pcaddr), 32'hFFFB);
        chk("hijack_vector", 32'(last_pcv), 32'h9000);
        psr_in[2] = 1'b0;
        fetch_req = 1'b1;
        #1;
        chk("hijack_pending_cleared", 32'(hold), 32'd0);
        tick(); fetch_req = 1'b0; tick();

        // Reset during the P push
        irq = 1'b1; clear_logs();
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        repeat (2) tick();
        res = 1'b1; tick();
        chk("res_midseq_rw", 32'(rw), 32'd1);
        chk("res_midseq_addr", 32'(address), 32'h0000);
        chk("res_midseq_hold", 32'(hold), 32'd1);
        res = 1'b0; irq = 1'b0; clear_logs();
        repeat (4) tick();
        chk("res_midseq_vector", 32'(last_pcv), 32'h1234);

        // Two-cycle stall in the vector low read
        psr_in[2] = 1'b0; irq = 1'b1; clear_logs();
        fetch_req = 1'b1; t0 = cyc + 1; tick(); fetch_req = 1'b0;
        repeat (3) tick();
        rdy = 1'b0; repeat (2) tick(); rdy = 1'b1;
        repeat (3) tick();
        irq = 1'b0;
        chk("stall_latency", 32'(last_pcl_cyc - t0), 32'd7);
        chk("stall_pcload_count", 32'(n_pcl), 32'd1);
        chk("stall_vector", 32'(last_pcv), 32'h5678);

        // Randomised traffic checked against the model every cycle
        for (int i = 0; i < 1500; i++) begin
            res = ($urandom_range(0, 79) == 0);
            irq = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 11) == 0) nmi = ~nmi;
            rdy = ($urandom_range(0, 7) != 0);
            fetch_req = 1'b0;
            if (!m_reset && m_step < 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    psr_in = 7'($urandom);
                    pc_in  = 16'($urandom);
                end
                if ($urandom_range(0, 2) == 0) begin
                    fetch_req = 1'b1;
                    rdy = 1'b1;
                end
            end
            tick();
        end
        res = 1'b0; fetch_req = 1'b0; rdy = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
